// File: rtl/vga_timing_out_if.sv
// VGA output bundle: active-low syncs plus blanked 4-bit colour channels.
// The timing generator drives it; the DAC/pad side consumes it.
interface vga_timing_out_if;
    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    modport master (
        output vga_hs,
        output vga_vs,
        output vga_r,
        output vga_g,
        output vga_b
    );

    modport slave (
        input vga_hs,
        input vga_vs,
        input vga_r,
        input vga_g,
        input vga_b
    );
endinterface

// File: rtl/vga_timing_out.sv
// VGA raster timing generator with a 2-clock output pipeline.
// Colour arrives one clock after its position and is blanked outside the visible area.
module vga_timing_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic             clk25m,
    input  logic             rst_n,
    input  logic [11:0]      usercolors,
    output logic [9:0]       hpos,
    output logic [9:0]       vpos,
    output logic             frame_tick,
    vga_timing_out_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic hs_raw;
    logic vs_raw;
    logic vid_raw;
    logic hs_d;
    logic vs_d;
    logic vid_d;

    // Raster counters: vpos advances only on the hpos wrap.
    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            hpos <= '0;
            vpos <= '0;
        end else if (hpos == H_LAST) begin
            hpos <= '0;
            vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    // Position-stage decode from the current counter values.
    always_comb begin
        hs_raw  = !((hpos >= HS_BEG) && (hpos < HS_END));
        vs_raw  = !((vpos >= VS_BEG) && (vpos < VS_END));
        vid_raw = (hpos < H_VIS) && (vpos < V_VIS);
    end

    assign frame_tick = (hpos == '0) && (vpos == '0);

    // Delay stage so sync/blank line up with the late-arriving colour.
    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            vid_d <= 1'b0;
        end else begin
            hs_d  <= hs_raw;
            vs_d  <= vs_raw;
            vid_d <= vid_raw;
        end
    end

    // Output register: syncs pass through, colour is blanked outside video.
    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            vga.vga_hs <= 1'b1;
            vga.vga_vs <= 1'b1;
            vga.vga_r  <= '0;
            vga.vga_g  <= '0;
            vga.vga_b  <= '0;
        end else begin
            vga.vga_hs <= hs_d;
            vga.vga_vs <= vs_d;
            vga.vga_r  <= vid_d ? usercolors[11:8] : 4'h0;
            vga.vga_g  <= vid_d ? usercolors[7:4]  : 4'h0;
            vga.vga_b  <= vid_d ? usercolors[3:0]  : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out with a shortened vertical frame.
// Horizontal timing uses the real 800-clock line.
module tb_vga_timing_out;

    localparam int HV = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VV = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    typedef struct {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        int          h;
        int          v;
    } exp_t;

    logic        clk25m = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] usercolors = 12'h000;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        frame_tick;

    vga_timing_out_if vif();

    vga_timing_out #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk25m     (clk25m),
        .rst_n      (rst_n),
        .usercolors (usercolors),
        .hpos       (hpos),
        .vpos       (vpos),
        .frame_tick (frame_tick),
        .vga        (vif.master)
    );

    always #20 clk25m = ~clk25m;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mh = 0;
    int   mv = 0;
    int   ph = 0;
    int   pv = 0;
    int   cmode = 0;
    exp_t q[$];

    function automatic logic [11:0] colfor(int h);
        logic [3:0] n;
        n = h[3:0];
        case (cmode)
            0:       return 12'hFFF;
            1:       return {n, n, n};
            default: return 12'($urandom);
        endcase
    endfunction

    // One clock: advance model, check counters, scoreboard outputs, drive colour.
    task automatic drive_cycle();
        logic        rs;
        exp_t        e;
        logic [11:0] got;
        logic [11:0] col;
        logic        vid;
        rs = rst_n;
        @(posedge clk25m);
        #1;
        cyc++;
        if (!rs) begin
            mh = 0;
            mv = 0;
        end else if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        total++;
        if (hpos !== 10'(mh) || vpos !== 10'(mv)) begin
            bad++;
            $display("FAIL pos cyc=%0d got h=%0d v=%0d want h=%0d v=%0d",
                     cyc, hpos, vpos, mh, mv);
        end
        total++;
        if (frame_tick !== ((mh == 0 && mv == 0) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL frame_tick cyc=%0d got %b at h=%0d v=%0d",
                     cyc, frame_tick, mh, mv);
        end
        got = {vif.vga_r, vif.vga_g, vif.vga_b};
        if (!rs) begin
            q.delete();
            total++;
            if (vif.vga_hs !== 1'b1 || vif.vga_vs !== 1'b1 || got !== 12'h000) begin
                bad++;
                $display("FAIL rst_out cyc=%0d got hs=%b vs=%b rgb=%h want 1 1 000",
                         cyc, vif.vga_hs, vif.vga_vs, got);
            end
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.rgb = 12'h000;
            e.h = -1;
            e.v = -1;
            q.push_back(e);
            usercolors = 12'h000;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (vif.vga_hs !== e.hs || vif.vga_vs !== e.vs || got !== e.rgb) begin
                    bad++;
                    $display("FAIL out cyc=%0d h=%0d v=%0d got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                             cyc, e.h, e.v, vif.vga_hs, vif.vga_vs, got, e.hs, e.vs, e.rgb);
                end
            end
            col = colfor(ph);
            usercolors = col;
            vid = (ph < HV) && (pv < VV);
            e.hs = !((ph >= HV + HF) && (ph < HV + HF + HS));
            e.vs = !((pv >= VV + VF) && (pv < VV + VF + VS));
            e.rgb = vid ? col : 12'h000;
            e.h = ph;
            e.v = pv;
            q.push_back(e);
        end
        ph = mh;
        pv = mv;
    endtask

    task automatic run_to(int h, int v);
        bit found;
        found = (mh == h && mv == v);
        for (int i = 0; i < HT * VT + 2 && !found; i++) begin
            drive_cycle();
            found = (mh == h && mv == v);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL run_to got h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) drive_cycle();
        total++;
        if (hpos !== 10'd0 || vpos !== 10'd0 || frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL reset_cnt got h=%0d v=%0d ft=%b want 0 0 1",
                     hpos, vpos, frame_tick);
        end
        total++;
        if (vif.vga_hs !== 1'b1 || vif.vga_vs !== 1'b1 ||
            {vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000) begin
            bad++;
            $display("FAIL reset_out got hs=%b vs=%b want 1 1 rgb 0",
                     vif.vga_hs, vif.vga_vs);
        end
    endtask

    task automatic test_line();
        int lo_start;
        int lo_len;
        cmode = 0;
        rst_n = 1'b1;
        lo_start = -1;
        lo_len = 0;
        for (int i = 1; i <= 802; i++) begin
            drive_cycle();
            if (vif.vga_hs === 1'b0) begin
                if (lo_start < 0) lo_start = i;
                lo_len++;
            end
            if (i == 800) begin
                total++;
                if (hpos !== 10'd0 || vpos !== 10'd1) begin
                    bad++;
                    $display("FAIL line_wrap got h=%0d v=%0d want 0 1", hpos, vpos);
                end
            end
        end
        total++;
        if (lo_start !== 658) begin
            bad++;
            $display("FAIL hs_start got %0d want 658", lo_start);
        end
        total++;
        if (lo_len !== HS) begin
            bad++;
            $display("FAIL hs_len got %0d want %0d", lo_len, HS);
        end
    endtask

    task automatic test_column();
        run_to(0, 2);
        cmode = 1;
        repeat (2 * HT) drive_cycle();
        cmode = 2;
        repeat (HT) drive_cycle();
        cmode = 0;
    endtask

    task automatic test_midreset();
        int hs_at[2];
        int vs_at[2];
        hs_at[0] = 700;
        vs_at[0] = 5;
        hs_at[1] = 600;
        vs_at[1] = 6;
        for (int k = 0; k < 2; k++) begin
            run_to(hs_at[k], vs_at[k]);
            rst_n = 1'b0;
            for (int j = 0; j < 3; j++) begin
                drive_cycle();
                total++;
                if (vif.vga_hs !== 1'b1 || vif.vga_vs !== 1'b1 ||
                    {vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000) begin
                    bad++;
                    $display("FAIL midrst_out k=%0d j=%0d hs=%b vs=%b", k, j,
                             vif.vga_hs, vif.vga_vs);
                end
            end
            total++;
            if (hpos !== 10'd0 || vpos !== 10'd0) begin
                bad++;
                $display("FAIL midrst_cnt k=%0d got h=%0d v=%0d want 0 0",
                         k, hpos, vpos);
            end
            rst_n = 1'b1;
            drive_cycle();
            total++;
            if (hpos !== 10'd1 || vpos !== 10'd0) begin
                bad++;
                $display("FAIL midrst_resume k=%0d got h=%0d v=%0d want 1 0",
                         k, hpos, vpos);
            end
            total++;
            if (vif.vga_hs !== 1'b1 || {vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000) begin
                bad++;
                $display("FAIL midrst_flush k=%0d hs=%b rgb=%h want 1 000", k,
                         vif.vga_hs, {vif.vga_r, vif.vga_g, vif.vga_b});
            end
        end
    endtask

    task automatic test_frame();
        int vs_low;
        int ticks;
        int t0;
        int t1;
        int pos_cyc;
        int fall_cyc;
        logic prev_vs;
        vs_low = 0;
        ticks = 0;
        t0 = -1;
        t1 = -1;
        pos_cyc = -1;
        fall_cyc = -1;
        prev_vs = vif.vga_vs;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            drive_cycle();
            if (vif.vga_vs === 1'b0) vs_low++;
            if (frame_tick === 1'b1) begin
                ticks++;
                if (t0 < 0) t0 = cyc;
                else if (t1 < 0) t1 = cyc;
            end
            if (pos_cyc < 0 && mh == 0 && mv == VV + VF) pos_cyc = cyc;
            if (pos_cyc >= 0 && fall_cyc < 0 && prev_vs === 1'b1 && vif.vga_vs === 1'b0)
                fall_cyc = cyc;
            prev_vs = vif.vga_vs;
        end
        total++;
        if (vs_low !== 4 * HT) begin
            bad++;
            $display("FAIL vs_len got %0d want %0d", vs_low, 4 * HT);
        end
        total++;
        if (fall_cyc - pos_cyc !== 2) begin
            bad++;
            $display("FAIL vs_start got %0d want 2", fall_cyc - pos_cyc);
        end
        total++;
        if (ticks !== 2) begin
            bad++;
            $display("FAIL tick_count got %0d want 2", ticks);
        end
        total++;
        if (t1 - t0 !== HT * VT) begin
            bad++;
            $display("FAIL tick_period got %0d want %0d", t1 - t0, HT * VT);
        end
    endtask

    task automatic test_wrap();
        run_to(HT - 1, VT - 1);
        total++;
        if (hpos !== 10'(HT - 1) || vpos !== 10'(VT - 1) || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pre got h=%0d v=%0d ft=%b", hpos, vpos, frame_tick);
        end
        drive_cycle();
        total++;
        if (hpos !== 10'd0 || vpos !== 10'd0 || frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL wrap got h=%0d v=%0d ft=%b want 0 0 1",
                     hpos, vpos, frame_tick);
        end
        repeat (4) drive_cycle();
    endtask

    initial begin
        test_reset();
        test_line();
        test_column();
        test_midreset();
        test_frame();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Port clk25m, input, 1, pixel clock; all logic is on its rising edge.
REQ-010 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-011 Port usercolors, input, 12, pixel colour {R[11:8],G[7:4],B[3:0]}; arrives one clock after the hpos/vpos it belongs to.
REQ-012 Port hpos, output, 10, current horizontal count, 0..H_TOTAL-1.
REQ-013 Port vpos, output, 10, current vertical count, 0..V_TOTAL-1.
REQ-014 Port frame_tick, output, 1, one-clock pulse when hpos=0 and vpos=0.
REQ-015 Port vga_hs, output, 1, horizontal sync, active-low.
REQ-016 Port vga_vs, output, 1, vertical sync, active-low.
REQ-017 Port vga_r / vga_g / vga_b, output, 4 each, blanked pixel colour.

Function
REQ-018 The block SHALL use H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-019 hpos SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-020 vpos SHALL increment by 1 only on the clock where hpos wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same clock.
REQ-021 Position-stage signals SHALL be decoded from the hpos/vpos values present in the same cycle:
- hs_raw = 0 iff H_VISIBLE+H_FP <= hpos < H_VISIBLE+H_FP+H_SYNC (656..751).
- vs_raw = 0 iff V_VISIBLE+V_FP <= vpos < V_VISIBLE+V_FP+V_SYNC (490..491).
- vid_raw = 1 iff hpos < H_VISIBLE and vpos < V_VISIBLE.
REQ-022 hs_raw, vs_raw and vid_raw SHALL pass through a 1-stage delay so that they align with usercolors.
REQ-023 The output register SHALL load, each clock: vga_hs and vga_vs from the delayed sync signals; vga_r/g/b from usercolors when the delayed vid is 1, otherwise 0.
REQ-024 Total latency from an hpos/vpos value to its vga_hs, vga_vs and vga_r/g/b outputs SHALL be exactly 2 clocks, and these outputs SHALL be mutually aligned.
REQ-025 frame_tick SHALL be combinational from the counters (hpos=0 and vpos=0), high for exactly 1 clock per frame (every 420000 clocks).
REQ-026 Outside the visible region, RGB SHALL be 0 regardless of usercolors; no colour SHALL leak in the 2 clocks after the visible region ends.
REQ-027 All counter arithmetic SHALL be unsigned 10-bit; the counters SHALL never hold a value >= their total.

Reset
REQ-028 While rst_n=0 at a clock edge: hpos=0, vpos=0, vga_hs=1, vga_vs=1, vga_r/g/b=0, and both pipeline stages cleared (sync=1, vid=0).
REQ-029 In the first cycle after rst_n rises, hpos=0 and vpos=0; counting resumes from there.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no partial sync pulse or colour emitted afterwards from pipeline contents.
REQ-031 frame_tick SHALL be 1 while held in reset (hpos=vpos=0), by the same decode.

Verification
REQ-032 Release reset, run 1 line: hpos reads 0..799 then 0; vpos steps 0->1 at the wrap; vga_hs is low for exactly 96 clocks, starting 658 clocks after reset release.
REQ-033 Run 1 full frame: vga_vs is low for exactly 2x800 clocks, starting when vpos=490 (+2 clocks); frame_tick fires once per 420000 clocks.
REQ-034 Drive usercolors=12'hFFF constantly: vga_r/g/b=F exactly for outputs corresponding to hpos 0..639 and vpos 0..479; 0 elsewhere, including hpos 640-641 at the output.
REQ-035 Drive usercolors equal to the registered hpos[3:0] replicated to 12 bits: each output pixel equals its own column, confirming the 1-clock input alignment.
REQ-036 Assert rst_n=0 at hpos=700, vpos=300 for 3 clocks, then release: the outputs show sync=1 and RGB=0 during reset, and the counters restart at 0,0.
REQ-037 Check at the wrap hpos=799, vpos=524: the next clock gives hpos=0, vpos=0 and frame_tick=1.
